// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t        : control-unit FSM states
//   DEFAULT_WIDTH  : default operand width
//   cnt_width()    : width of the iteration counter for a given operand width
package mult_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD_Q = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_t;

    // The counter must hold 0..width-1; a one-bit counter is the floor so
    // degenerate widths still produce a legal vector.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_cu.sv
// Control unit for the shift-add multiplier: FSM plus iteration counter.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   start    : multiply request, honoured only in IDLE
//   m_ld     : load multiplicand register from the operand bus
//   a_clr    : clear accumulator and carry
//   q_ld     : load multiplier register from the operand bus
//   shift    : perform one add/shift iteration
//   done     : one-cycle completion pulse
module shift_add_multiplier_cu
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic m_ld,
    output logic a_clr,
    output logic q_ld,
    output logic shift,
    output logic done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_next;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The counter restarts with each accepted start and advances once per
    // iteration; it is left untouched in LD_Q and FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (a_clr) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        m_ld       = 1'b0;
        a_clr      = 1'b0;
        q_ld       = 1'b0;
        shift      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    m_ld       = 1'b1;
                    a_clr      = 1'b1;
                    state_next = LD_Q;
                end
            end
            LD_Q: begin
                q_ld       = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                shift = 1'b1;
                // cnt still shows the value before this edge's increment,
                // so LAST marks the final of WIDTH iterations.
                if (cnt == LAST) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier (datapath + control unit).
// Operands arrive one per cycle on In_bus: multiplicand with start, the
// multiplier on the following cycle. WIDTH iterations later the 2*WIDTH-bit
// product is presented as {P_hi_bus, P_lo_bus} and done pulses for one cycle.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   start    : multiply request (sampled only when idle)
//   In_bus   : shared operand bus
//   P_hi_bus : product high half (accumulator A)
//   P_lo_bus : product low half (multiplier/low register Q)
//   done     : one-cycle completion pulse
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In_bus,
    output logic [WIDTH-1:0] P_hi_bus,
    output logic [WIDTH-1:0] P_lo_bus,
    output logic             done
);

    logic             m_ld;
    logic             a_clr;
    logic             q_ld;
    logic             shift;

    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic             c;
    logic [WIDTH:0]   sum;

    shift_add_multiplier_cu #(
        .WIDTH (WIDTH)
    ) u_cu (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m_ld  (m_ld),
        .a_clr (a_clr),
        .q_ld  (q_ld),
        .shift (shift),
        .done  (done)
    );

    // C is zero on entry to every iteration (cleared at start, and the shift
    // always moves a zero into it), so {C, A} is the zero-extended
    // accumulator and the sum's top bit is the fresh carry.
    always_comb begin
        sum = {c, a} + (q[0] ? {1'b0, m} : {(WIDTH + 1){1'b0}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
            a <= '0;
            q <= '0;
            c <= 1'b0;
        end else begin
            if (m_ld) begin
                m <= In_bus;
            end
            if (a_clr) begin
                a <= '0;
                c <= 1'b0;
            end
            if (q_ld) begin
                q <= In_bus;
            end
            // {C, A, Q} <= {0, sum, Q} >> 1: the carry lands in A's MSB and
            // the sum's LSB moves into Q's MSB as the consumed bit leaves.
            if (shift) begin
                c <= 1'b0;
                a <= sum[WIDTH:1];
                q <= {sum[0], q[WIDTH-1:1]};
            end
        end
    end

    assign P_hi_bus = a;
    assign P_lo_bus = q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus random
// operands, compared against plain integer multiplication.
module tb_shift_add_multiplier;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in_bus;
    logic [W-1:0] p_hi;
    logic [W-1:0] p_lo;
    logic         done;

    int errs   = 0;
    int checks = 0;

    shift_add_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .In_bus   (in_bus),
        .P_hi_bus (p_hi),
        .P_lo_bus (p_lo),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full multiply. The edge sampling start is E0; edge numbers count
    // from there. With hold set, start stays high through LD_Q, CALC and the
    // FIN cycle and drops only once the unit is back in IDLE.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit hold, input string tag);
        int           prod;
        int           done_cnt;
        int           done_edge;
        logic [W-1:0] hi_at;
        logic [W-1:0] lo_at;
        prod      = int'(x) * int'(y);
        done_cnt  = 0;
        done_edge = -1;
        hi_at     = '0;
        lo_at     = '0;
        start  = 1'b1;
        in_bus = x;
        tick;                       // E0
        if (!hold) start = 1'b0;
        in_bus = y;
        tick;                       // E1
        for (int e = 2; e <= W + 4; e++) begin
            in_bus = W'($urandom);
            if (hold && e == W + 3) start = 1'b0;
            tick;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = e;
                    hi_at     = p_hi;
                    lo_at     = p_lo;
                end
            end
        end
        chk({tag, ".done_pulses"}, done_cnt, 1);
        chk({tag, ".done_edge"}, done_edge, W + 1);
        chk({tag, ".hi"}, hi_at, (prod >> W) & ((1 << W) - 1));
        chk({tag, ".lo"}, lo_at, prod & ((1 << W) - 1));
        chk({tag, ".hi_hold"}, p_hi, (prod >> W) & ((1 << W) - 1));
        chk({tag, ".lo_hold"}, p_lo, prod & ((1 << W) - 1));
    endtask

    // Start an operation, then pulse reset asynchronously during the third
    // CALC cycle (between E3 and E4) and make sure no done ever appears.
    task automatic run_abort(input logic [W-1:0] x, input logic [W-1:0] y);
        int done_cnt;
        done_cnt = 0;
        start  = 1'b1;
        in_bus = x;
        tick;                       // E0
        start  = 1'b0;
        in_bus = y;
        tick;                       // E1
        tick;                       // E2
        tick;                       // E3
        #1 rst = 1'b1;
        #1;
        chk("abort.hi_async", p_hi, 0);
        chk("abort.lo_async", p_lo, 0);
        chk("abort.done_async", done, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            tick;
            if (done === 1'b1) done_cnt++;
        end
        chk("abort.no_done", done_cnt, 0);
        chk("abort.hi_after", p_hi, 0);
        chk("abort.lo_after", p_lo, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        in_bus = '0;
        #2;
        chk("reset.hi", p_hi, 0);
        chk("reset.lo", p_lo, 0);
        chk("reset.done", done, 0);
        tick;
        rst = 1'b0;
        tick;

        run_op(6'd6,  6'd7,  1'b0, "6x7");
        run_op(6'd63, 6'd63, 1'b0, "63x63");
        run_op(6'd0,  6'd45, 1'b0, "0x45");
        run_op(6'd45, 6'd0,  1'b0, "45x0");
        run_op(6'd5,  6'd9,  1'b1, "5x9_hold");
        tick;
        chk("after_hold.done", done, 0);
        chk("after_hold.lo", p_lo, 45);

        run_abort(6'd20, 6'd30);
        run_op(6'd20, 6'd30, 1'b0, "20x30");

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = W'($urandom);
            y = W'($urandom);
            run_op(x, y, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-add multiplier, the companion to the restoring divider in the arithmetic-unit suite. It shares the divider's narrow shared-bus protocol: operands arrive one per cycle on a single `In_bus` after `start`, results appear on two output buses, and `done` marks completion. It multiplies two WIDTH-bit operands over WIDTH iterations and produces a 2·WIDTH-bit product, split into high and low halves.

## Interface
- WIDTH, default 6: operand width and width of each output bus.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- In_bus  in  WIDTH  operand bus:
  - multiplicand in the start cycle;
  - multiplier in the following cycle.
- P_hi_bus  out  WIDTH  product bits [2·WIDTH-1:WIDTH] (register A).
- P_lo_bus  out  WIDTH  product bits [WIDTH-1:0] (register Q).
- done  out  1  one-cycle completion pulse.

## Operation
- Datapath registers:
  - M (WIDTH): multiplicand.
  - A (WIDTH): accumulator / high half.
  - Q (WIDTH): multiplier / low half.
  - C (1): carry.
  - cnt: iteration counter, $clog2(WIDTH) bits.
- FSM states: IDLE, LD_Q, CALC, FIN.
- IDLE: when start=1, load M←In_bus and clear A, C and cnt. Go to LD_Q. When start=0, hold all registers.
- LD_Q: load Q←In_bus unconditionally. Go to CALC.
- CALC, one iteration per edge:
  - sum = {1'b0,A} + (Q[0] ? M : 0), giving WIDTH+1 bits.
  - {C,A,Q} ← {1'b0, sum, Q} >> 1. The sum's carry bit becomes A's MSB, and the LSB of the sum shifts into Q's MSB.
  - cnt++.
  - After the iteration where cnt==WIDTH-1, go to FIN. Exactly WIDTH iterations occur.
- FIN: done=1. Go to IDLE. All registers hold.
- Outputs are direct register views, never combinational from In_bus. The product remains stable from FIN until the next accepted start clears A.
- start is ignored in LD_Q, CALC and FIN, including the FIN cycle itself.
- Arithmetic is unsigned only. The product cannot overflow 2·WIDTH bits.

## Timing
- Reset: state=IDLE and M=A=Q=C=cnt=0. As a result P_hi_bus=0, P_lo_bus=0 and done=0 immediately, without waiting for a clock edge.
- Reset mid-operation aborts the operation with no done pulse. The first start after reset is accepted normally.
- Edge E0 samples start=1 together with the multiplicand.
- Edge E1 latches the multiplier.
- Edges E2..E(WIDTH+1) perform the iterations.
- done is high for exactly the one cycle following edge E(WIDTH+1). For WIDTH=6 that is 8 cycles after E0.
- Back-to-back operation: a new start is accepted no earlier than the first cycle after done, so the minimum issue interval is WIDTH+3 cycles.

## Structure
- Shared package `mult_pkg`:
  - state enum (IDLE, LD_Q, CALC, FIN);
  - default WIDTH constant;
  - iteration-count function for the counter width.
- One sub-module, `shift_add_multiplier_cu`:
  - contains the FSM and iteration counter;
  - drives M_ld, Q_ld, A_clr, shift and done.
- The datapath (M, A, Q, C, adder, shifter) lives in the top, mirroring the divider's DP/CU split.

## Test plan
- Reset with no clock edge → P_hi_bus=0, P_lo_bus=0, done=0.
- start with In_bus=6, then 7 → done exactly 8 cycles after the start edge; P_hi_bus=0, P_lo_bus=42.
- 63×63 → P_hi_bus=62, P_lo_bus=1 (product 3969). This exercises the carry into A's MSB.
- 0×45 → product 0. Then 45×0 → product 0. done fires once per operation.
- start held high through CALC and FIN for 5×9 → single done; product 45; the next operation begins only after re-entering IDLE.
- rst pulsed during the 3rd CALC cycle of 20×30 → outputs 0 and no done. A subsequent 20×30 gives P_hi_bus=9, P_lo_bus=24 (product 600).
